reg_dump: RTL

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/reg_dump.sv
// +----------------------------------------------------------------------------+
// | reg_dump : streams a wrapping range of regfile entries out over a          |
// |            valid/ready port. Optional trailing checksum beat when          |
// |            REG_DUMP_CHECKSUM_EN is defined.                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_dump (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  first_addr,
  input  logic [3:0]  last_addr,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_addr,
  output logic        out_last,
  output logic        out_sum,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_STREAM = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic c_LAST_ON_REG = 1'b0;
`else
  localparam logic c_LAST_ON_REG = 1'b1;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [3:0]  r_ptr;
  logic [4:0]  r_left;
  logic [15:0] r_data;
  logic [3:0]  r_addr;
  logic        r_valid;
  logic        r_last;
  logic [4:0]  w_span;
  logic        w_fire;
  logic        w_load;
  logic        w_kick;

  assign w_span = {1'b0, last_addr - first_addr} + 5'd1;
  assign w_fire = r_valid & out_ready;
  assign w_load = ~r_valid | w_fire;
  assign w_kick = (r_state == c_IDLE) & start;

  // The first register is fetched on the start edge itself, hence the bypass.
  assign rd_addr = w_kick ? first_addr : r_ptr;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next = c_STREAM;
      c_STREAM: if (w_fire && r_last) w_next = c_DONE;
      c_DONE:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_STREAM: busy = 1'b1;
      c_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [15:0] r_sum;
  logic        r_pend;
  logic        r_osum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum  <= 16'd0;
      r_pend <= 1'b0;
    end else if (w_kick) begin
      r_sum  <= rd_data;
      r_pend <= 1'b1;
    end else if (r_state == c_STREAM && w_load) begin
      if (r_left != 5'd0) r_sum  <= r_sum + rd_data;
      else if (r_pend)    r_pend <= 1'b0;
    end
  end
  assign out_sum = r_osum;
`else
  assign out_sum = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr   <= 4'd0;
      r_left  <= 5'd0;
      r_data  <= 16'd0;
      r_addr  <= 4'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_osum  <= 1'b0;
`endif
    end else if (w_kick) begin
      r_ptr   <= first_addr + 4'd1;
      r_left  <= w_span - 5'd1;
      r_data  <= rd_data;
      r_addr  <= first_addr;
      r_valid <= 1'b1;
      r_last  <= c_LAST_ON_REG && (w_span == 5'd1);
`ifdef REG_DUMP_CHECKSUM_EN
      r_osum  <= 1'b0;
`endif
    end else if (r_state == c_STREAM && w_load) begin
      if (r_left != 5'd0) begin
        r_ptr   <= r_ptr + 4'd1;
        r_left  <= r_left - 5'd1;
        r_data  <= rd_data;
        r_addr  <= r_ptr;
        r_valid <= 1'b1;
        r_last  <= c_LAST_ON_REG && (r_left == 5'd1);
`ifdef REG_DUMP_CHECKSUM_EN
      end else if (r_pend) begin
        r_data  <= r_sum;
        r_addr  <= 4'd0;
        r_valid <= 1'b1;
        r_last  <= 1'b1;
        r_osum  <= 1'b1;
`endif
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        r_osum  <= 1'b0;
`endif
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_addr  = r_addr;
  assign out_last  = r_last;

endmodule

`default_nettype wire
